// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_timer block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } status_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// First-word fall-through FIFO for lap captures; head, count and flags are registered.
module stopwatch_lap_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full_q || do_pop);
    assign rd_next = rd_ptr_q + AW'(1);

    // Head is kept as its own register so the output is the next entry
    // (or the incoming word when it lands in an empty/draining FIFO).
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (!do_push && do_pop)
            count_d = count_q - CW'(1);

        head_d = head_q;
        if (count_d == '0)
            head_d = '0;
        else if (empty_q)
            head_d = din;
        else if (do_pop)
            head_d = (count_q == CW'(1)) ? din : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)
                rd_ptr_q <= rd_next;
            count_q <= count_d;
            head_q  <= head_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign dout  = head_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/stopwatch_timer.sv
// Up/down minutes:seconds stopwatch-timer with prescaler, preload and expiry.
// Define STOPWATCH_LAP_EN to build the lap-capture FIFO; otherwise lap outputs are tied to 0.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 100_000_000,
    parameter int unsigned MIN_W     = 8,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             clear,
    input  logic                             mode,
    input  logic                             load,
    input  logic [MIN_W-1:0]                 load_min,
    input  logic [5:0]                       load_sec,
    input  logic                             lap,
    input  logic                             lap_rd,
    output logic [MIN_W-1:0]                 minutes,
    output logic [5:0]                       seconds,
    output logic [1:0]                       status,
    output logic                             expired,
    output logic                             lap_valid,
    output logic [MIN_W-1:0]                 lap_min,
    output logic [5:0]                       lap_sec,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic                             lap_overflow
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    status_t          state_q, state_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             expired_q, expired_d;
    logic             tick, count_zero;

    assign count_zero = (min_q == '0) && (sec_q == '0);

    // The prescaler advances on every edge seen in RUNNING, including the one
    // that accepts stop, so pause/resume never shifts the tick phase.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        presc_d   = presc_q;
        min_d     = min_q;
        sec_d     = sec_q;
        expired_d = 1'b0;
        tick      = 1'b0;

        if (state_q == ST_RUNNING) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (tick) begin
            if (!mode_q) begin
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    min_d = min_q + MIN_W'(1);
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                if (sec_q == '0) begin
                    sec_d = SEC_MAX;
                    min_d = min_q - MIN_W'(1);
                end else begin
                    sec_d = sec_q - 6'd1;
                end
                if (min_q == '0 && sec_q == 6'd1) begin
                    state_d   = ST_EXPIRED;
                    expired_d = 1'b1;
                end
            end
        end

        if (clear) begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            min_d     = '0;
            sec_d     = '0;
            expired_d = 1'b0;
        end else if (load && state_q != ST_RUNNING) begin
            state_d   = (state_q == ST_PAUSED) ? ST_PAUSED : ST_IDLE;
            presc_d   = '0;
            min_d     = load_min;
            sec_d     = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
            expired_d = 1'b0;
        end else if (stop) begin
            if (state_q == ST_RUNNING && state_d == ST_RUNNING)
                state_d = ST_PAUSED;
        end else if (start) begin
            if (state_q == ST_IDLE) begin
                if (!(mode && count_zero)) begin
                    state_d = ST_RUNNING;
                    mode_d  = mode;
                    presc_d = '0;
                end
            end else if (state_q == ST_PAUSED) begin
                if (!(mode_q && count_zero))
                    state_d = ST_RUNNING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            presc_q   <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            expired_q <= expired_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign status  = state_q;
    assign expired = expired_q;

`ifdef STOPWATCH_LAP_EN
    logic               lap_push, lap_pop, fifo_full, fifo_empty;
    logic [MIN_W+5:0]   fifo_dout;
    logic               overflow_q;

    assign lap_push = lap && !clear && (state_q == ST_RUNNING);
    assign lap_pop  = lap_rd && !clear && !fifo_empty;

    stopwatch_lap_fifo #(
        .WIDTH (MIN_W + 6),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (lap_push),
        .din   ({min_q, sec_q}),
        .pop   (lap_pop),
        .dout  (fifo_dout),
        .count (lap_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_q <= 1'b0;
        else if (clear)
            overflow_q <= 1'b0;
        else if (lap_push && fifo_full && !lap_pop)
            overflow_q <= 1'b1;
    end

    assign lap_valid    = !fifo_empty;
    assign lap_min      = fifo_dout[MIN_W+5:6];
    assign lap_sec      = fifo_dout[5:0];
    assign lap_overflow = overflow_q;
`else
    logic unused_lap_inputs;
    assign unused_lap_inputs = lap ^ lap_rd;

    assign lap_valid    = 1'b0;
    assign lap_min      = '0;
    assign lap_sec      = '0;
    assign lap_count    = '0;
    assign lap_overflow = 1'b0;
`endif

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised up/down stopwatch-timer. It generalises the minutes/seconds stopwatch with a configurable tick prescaler, configurable minutes width, a count-down mode with expiry, preload of a start value, and an optional lap-capture FIFO. It sits beside the display and control logic as a standalone timing peripheral. All outputs are registered.

## Interface
- `CLK_DIV`, default 100_000_000: clk cycles per one-second tick (≥2).
- `MIN_W`, default 8: minutes counter width.
- `LAP_DEPTH`, default 4: lap FIFO entries (power of two, ≥2).

- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle pulse; begin or resume counting.
- `stop`  in  1: single-cycle pulse; pause.
- `clear`  in  1: single-cycle pulse; return to IDLE, count 00:00, flush laps.
- `mode`  in  1: 0 = count up, 1 = count down. Sampled only when start is accepted from IDLE.
- `load`  in  1: pulse; preload count from `load_min`/`load_sec`.
- `load_min`  in  MIN_W: preload minutes.
- `load_sec`  in  6: preload seconds; values >59 clamp to 59.
- `lap`  in  1: pulse; capture the current count.
- `lap_rd`  in  1: pop the lap FIFO head.
- `minutes`  out  MIN_W: current minutes.
- `seconds`  out  6: current seconds, 0..59.
- `status`  out  2: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.
- `expired`  out  1: one-cycle pulse on entering EXPIRED.
- `lap_valid`  out  1: FIFO not empty.
- `lap_min`  out  MIN_W: head entry minutes (first-word fall-through).
- `lap_sec`  out  6: head entry seconds.
- `lap_count`  out  $clog2(LAP_DEPTH+1): occupancy.
- `lap_overflow`  out  1: sticky; set when a lap is dropped on full.

## Operation
- Reset value of every output is 0; `status` resets to IDLE.
- Same-cycle control priority: clear > load > stop > start. Simultaneous start and stop: stop wins.
- State transitions:
  - IDLE → RUNNING on start. Latches `mode` and zeroes the prescaler.
  - PAUSED → RUNNING on start. The prescaler resumes where it left off.
  - RUNNING → PAUSED on stop. The prescaler and count are held.
  - Any state → IDLE on clear.
  - load is accepted in IDLE, PAUSED or EXPIRED. It writes the count and zeroes the prescaler; the resulting state is IDLE, except that load from PAUSED stays PAUSED. load is ignored while RUNNING.
  - EXPIRED ignores start and stop. Only clear or load leaves EXPIRED.
  - start in down mode with count 00:00 is ignored (state stays IDLE or PAUSED).
- Prescaler: counts 0..CLK_DIV-1, only while RUNNING. The tick fires when it equals CLK_DIV-1, and the prescaler then wraps to 0.
- Up mode, on tick:
  - seconds 59 → 0 and minutes +1.
  - Minutes at 2^MIN_W-1 with seconds 59 wraps to 00:00 and keeps running.
- Down mode, on tick:
  - seconds 0 → 59 and minutes −1.
  - A tick that produces 00:00 sets status EXPIRED and pulses `expired` in the same cycle the count becomes 00:00.
- Lap push:
  - Accepted only while RUNNING; ignored in other states.
  - The pushed value is the count visible on the outputs in that cycle (the pre-tick value if a tick coincides).
  - When full, the push is dropped and `lap_overflow` is set.
- Lap pop: `lap_rd` while `lap_valid` pops the head; `lap_rd` when empty is ignored.
- Push and pop in the same cycle both succeed, including when full; occupancy is unchanged.
- clear empties the FIFO and clears `lap_overflow`. rst does the same.

## Timing
- Control-to-status latency: 1 cycle.
- First tick after start from IDLE: the count changes on the CLK_DIV-th rising edge after the edge that accepted start.
- Pause/resume preserves phase: total RUNNING cycles between ticks is always CLK_DIV.
- Lap data appears on `lap_min`/`lap_sec` with `lap_valid` 1 cycle after the push edge. A pop updates the head on the next edge.
- rst asserted mid-count forces all state and outputs to reset values immediately (asynchronously). Operation resumes on the first edge after deassertion.

## Configuration
- `STOPWATCH_LAP_EN`
  - Defined: lap FIFO instantiated; behaviour as above.
  - Undefined: no FIFO storage. `lap` and `lap_rd` are ignored; `lap_valid`, `lap_min`, `lap_sec`, `lap_count` and `lap_overflow` are tied to 0.
  - The port list is identical in both builds.

## Structure
- Package `stopwatch_pkg` holds:
  - status encodings `ST_IDLE`, `ST_RUNNING`, `ST_PAUSED`, `ST_EXPIRED`;
  - `SEC_MAX` = 59;
  - the 2-bit status typedef.
- One sub-module, `stopwatch_lap_fifo`: synchronous FWFT FIFO with parameters width and depth, push/pop ports, count and full/empty flags. Overflow tracking stays in the top level.

## Test plan
- CLK_DIV=4, start, then 8 cycles → 00:02, status 01. stop → status 10 and count frozen. start again → next tick arrives after the remaining prescaler cycles, not a full period.
- Up-mode rollover: load 00:59 with MIN_W=2, run 1 tick → 01:00. Load 03:59, run 1 tick → 00:00, still RUNNING.
- Down mode: load 01:00, mode=1, start → 00:59 after 1 tick. Load 00:02 → `expired` single-cycle pulse exactly as count hits 00:00, status 11. Further start is ignored. clear → 00 status and 00:00.
- Simultaneous start+stop from PAUSED → stays PAUSED. clear+load in the same cycle → IDLE at 00:00. load_sec=63 → seconds 59.
- Laps with LAP_DEPTH=4: push 5 laps while RUNNING → lap_count 4 and lap_overflow 1. Pops return the first four values in order. Push+pop together when full → count stays 4.
- rst pulse mid-run at 00:03 → all outputs 0 and status IDLE with no clock edge required. Rebuild without `STOPWATCH_LAP_EN` → lap outputs stay 0 under identical stimulus.
